// File: rtl/downcounter_timer.sv
// Loadable, prescaled down-counter: counts a programmed value to zero, pulses tc,
// and optionally auto-reloads to act as a periodic tick generator.
module downcounter_timer #(
    parameter int WIDTH = 3,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [PW-1:0]    presc,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_cnt_q, presc_cnt_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             tick;

    // >= rather than == so a live reduction of presc never has to wrap around
    assign tick = (presc_cnt_q >= presc);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        presc_cnt_d = presc_cnt_q;
        tc_d        = 1'b0;
        done_d      = done_q;

        if (load) begin
            count_d     = load_val;
            reload_d    = load_val;
            presc_cnt_d = '0;
            done_d      = 1'b0;
            if (state_q == DONE) state_d = IDLE;
        end

        if (stop) begin
            if (state_d == RUN) begin
                state_d     = IDLE;
                presc_cnt_d = '0;
            end
        end else if (start && (state_d != RUN)) begin
            // start sees the freshly loaded value when load arrives in the same cycle
            done_d      = 1'b0;
            presc_cnt_d = '0;
            if (count_d != '0) begin
                state_d = RUN;
            end else begin
                state_d = DONE;
                tc_d    = 1'b1;
                done_d  = 1'b1;
            end
        end else if ((state_q == RUN) && !load) begin
            if (tick) begin
                presc_cnt_d = '0;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    tc_d = 1'b1;
                    if (auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                presc_cnt_d = presc_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            presc_cnt_q <= '0;
            tc_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            presc_cnt_q <= presc_cnt_d;
            tc_q        <= tc_d;
            done_q      <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_downcounter_timer.sv
// Directed bench for downcounter_timer: hand-computed count/busy/tc/done after each clock.
module tb_downcounter_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [2:0] load_val;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] presc;
    logic [2:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    int seq_p2[9]     = '{3, 3, 2, 2, 2, 1, 1, 1, 0};
    int seq_fast[13]  = '{6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 0};

    downcounter_timer #(.WIDTH(3), .PW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .presc      (presc),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    // one clock edge, then release all pulse inputs
    task automatic cyc();
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        auto_reload = 1'b0; presc = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();
        chk_all("reset", 0, 0, 0, 0);

        // rst in the middle of RUN
        load = 1'b1; load_val = 3'd3; cyc();
        chk_all("rst_load3", 3, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("rst_run", 3, 1, 0, 0);
        rst = 1'b1; cyc();
        chk_all("rst_midrun", 0, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("start_zero_a", 0, 0, 1, 1);
        cyc();
        chk_all("start_zero_b", 0, 0, 0, 1);

        // load 5, presc 0: one decrement per cycle
        load = 1'b1; load_val = 3'd5; cyc();
        chk_all("p0_load", 5, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("p0_run", 5, 1, 0, 0);
        for (int i = 4; i >= 1; i--) begin
            cyc();
            chk_all($sformatf("p0_cnt%0d", i), i, 1, 0, 0);
        end
        cyc();
        chk_all("p0_term", 0, 0, 1, 1);
        cyc();
        chk_all("p0_after", 0, 0, 0, 1);

        // load 3, presc 2: each value held three cycles
        presc = 4'd2;
        load = 1'b1; load_val = 3'd3; cyc();
        chk_all("p2_load", 3, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("p2_run", 3, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk_all($sformatf("p2_e%0d", i + 1), seq_p2[i], (i == 8) ? 0 : 1,
                    (i == 8) ? 1 : 0, (i == 8) ? 1 : 0);
        end
        cyc();
        chk_all("p2_after", 0, 0, 0, 1);

        // auto-reload periodic ticks, then drop auto_reload
        presc = 4'd0; auto_reload = 1'b1;
        load = 1'b1; load_val = 3'd2; cyc();
        chk_all("ar_load", 2, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("ar_run", 2, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_all($sformatf("ar_e%0d", i + 1), (i % 2 == 0) ? 1 : 2, 1,
                    (i % 2 == 0) ? 0 : 1, 0);
        end
        auto_reload = 1'b0;
        cyc();
        chk_all("ar_off1", 1, 1, 0, 0);
        cyc();
        chk_all("ar_off_term", 0, 0, 1, 1);

        // collisions
        load = 1'b1; load_val = 3'd7; start = 1'b1; cyc();
        chk_all("ld7_start_done", 7, 1, 0, 0);
        cyc();
        chk_all("ld7_dec", 6, 1, 0, 0);
        stop = 1'b1; start = 1'b1; cyc();
        chk_all("stop_start", 6, 0, 0, 0);
        cyc();
        chk_all("idle_hold", 6, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("resume", 6, 1, 0, 0);
        for (int i = 5; i >= 2; i--) begin
            cyc();
            chk_all($sformatf("resume_cnt%0d", i), i, 1, 0, 0);
        end
        load = 1'b1; load_val = 3'd6; cyc();
        chk_all("ld6_in_run", 6, 1, 0, 0);
        cyc();
        chk_all("ld6_dec", 5, 1, 0, 0);
        stop = 1'b1; cyc();
        chk_all("stop_run", 5, 0, 0, 0);
        load = 1'b1; load_val = 3'd0; cyc();
        chk_all("ld0", 0, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("start0_a", 0, 0, 1, 1);
        cyc();
        chk_all("start0_b", 0, 0, 0, 1);

        // live prescaler reduction 7 -> 1 with presc_cnt at 4
        presc = 4'd7;
        load = 1'b1; load_val = 3'd7; cyc();
        chk_all("pr_load", 7, 0, 0, 0);
        start = 1'b1; cyc();
        chk_all("pr_run", 7, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_all($sformatf("pr_slow%0d", i + 1), 7, 1, 0, 0);
        end
        presc = 4'd1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            chk_all($sformatf("pr_fast%0d", i + 1), seq_fast[i], (i == 12) ? 0 : 1,
                    (i == 12) ? 1 : 0, (i == 12) ? 1 : 0);
        end
        cyc();
        chk_all("pr_no_underflow", 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
